// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants and small decode helpers used by
// the timing generator and by downstream pixel/colour generators.
package vga_timing_pkg;

    localparam int unsigned COUNT_W = 10;

    localparam int unsigned H_TOTAL_640      = 800;
    localparam int unsigned H_SYNC_640       = 96;
    localparam int unsigned H_DISP_START_640 = 144;
    localparam int unsigned H_DISP_END_640   = 784;

    localparam int unsigned V_TOTAL_480      = 525;
    localparam int unsigned V_SYNC_480       = 2;
    localparam int unsigned V_DISP_START_480 = 35;
    localparam int unsigned V_DISP_END_480   = 515;

    // Visible-area origin, so pixel generators can convert raster to screen coordinates
    localparam logic [COUNT_W-1:0] VIS_ORIGIN_X = 10'd144;
    localparam logic [COUNT_W-1:0] VIS_ORIGIN_Y = 10'd35;

    typedef struct packed {
        logic [COUNT_W-1:0] x;
        logic [COUNT_W-1:0] y;
    } raster_pos_t;

    // Limits are one bit wider than the counters so an exclusive bound of 1024 still works
    function automatic logic below(input logic [COUNT_W-1:0] val,
                                   input logic [COUNT_W:0]   lim);
        below = ({1'b0, val} < lim);
    endfunction

    function automatic logic in_window(input logic [COUNT_W-1:0] val,
                                       input logic [COUNT_W:0]   lo,
                                       input logic [COUNT_W:0]   hi);
        in_window = ({1'b0, val} >= lo) && ({1'b0, val} < hi);
    endfunction

endpackage

// File: rtl/clk_enable_div.sv
// Generic divide-by-DIV single-cycle enable: one registered pulse every DIV clocks,
// the first one DIV clocks after reset release.
module clk_enable_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic o_en
);

    localparam int unsigned        CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_en;

    if (DIV < 1) begin : g_bad_div
        $error("clk_enable_div: DIV must be >= 1");
    end

    // Free-running divide counter; the enable is registered from the terminal count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_en  <= 1'b0;
        end else begin
            r_en <= (r_cnt == LAST);
            if (r_cnt == LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_en = r_en;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel enable, h/v counters, zero-skew registered sync and
// visible-area flags, plus frame_start / move_tick pacing pulses.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned H_TOTAL      = H_TOTAL_640,
    parameter int unsigned H_SYNC       = H_SYNC_640,
    parameter int unsigned H_DISP_START = H_DISP_START_640,
    parameter int unsigned H_DISP_END   = H_DISP_END_640,
    parameter int unsigned V_TOTAL      = V_TOTAL_480,
    parameter int unsigned V_SYNC       = V_SYNC_480,
    parameter int unsigned V_DISP_START = V_DISP_START_480,
    parameter int unsigned V_DISP_END   = V_DISP_END_480,
    parameter int unsigned MOVE_DIV     = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               pix_en,
    output logic [COUNT_W-1:0] hCount,
    output logic [COUNT_W-1:0] vCount,
    output logic               hSync,
    output logic               vSync,
    output logic               bright,
    output logic               frame_start,
    output logic               move_tick
);

    localparam logic [COUNT_W-1:0] H_LAST = COUNT_W'(H_TOTAL - 1);
    localparam logic [COUNT_W-1:0] V_LAST = COUNT_W'(V_TOTAL - 1);
    localparam logic [COUNT_W:0]   H_SYNC_X  = (COUNT_W+1)'(H_SYNC);
    localparam logic [COUNT_W:0]   H_START_X = (COUNT_W+1)'(H_DISP_START);
    localparam logic [COUNT_W:0]   H_END_X   = (COUNT_W+1)'(H_DISP_END);
    localparam logic [COUNT_W:0]   V_SYNC_X  = (COUNT_W+1)'(V_SYNC);
    localparam logic [COUNT_W:0]   V_START_X = (COUNT_W+1)'(V_DISP_START);
    localparam logic [COUNT_W:0]   V_END_X   = (COUNT_W+1)'(V_DISP_END);

    localparam int unsigned        FC_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [FC_W-1:0]    FC_LAST = FC_W'(MOVE_DIV - 1);

    if (!(H_SYNC < H_DISP_START && H_DISP_START < H_DISP_END &&
          H_DISP_END <= H_TOTAL && H_TOTAL <= 1024)) begin : g_bad_h
        $error("vga_timing_gen: illegal horizontal timing parameters");
    end
    if (!(V_SYNC < V_DISP_START && V_DISP_START < V_DISP_END &&
          V_DISP_END <= V_TOTAL && V_TOTAL <= 1024)) begin : g_bad_v
        $error("vga_timing_gen: illegal vertical timing parameters");
    end
    if (CLK_DIV < 1 || MOVE_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV and MOVE_DIV must be >= 1");
    end

    logic               w_pix_en;
    logic [COUNT_W-1:0] w_h_next;
    logic [COUNT_W-1:0] w_v_next;
    logic               w_frame_wrap;

    logic [COUNT_W-1:0] r_h_count;
    logic [COUNT_W-1:0] r_v_count;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_bright;
    logic               r_frame_start;
    logic               r_move_tick;
    logic [FC_W-1:0]    r_frame_cnt;

    clk_enable_div #(
        .DIV (CLK_DIV)
    ) u_pix_div (
        .clk  (clk),
        .rst  (rst),
        .o_en (w_pix_en)
    );

    // Next-state raster position; the sync/bright decode below is taken from this
    always_comb begin
        w_h_next     = r_h_count;
        w_v_next     = r_v_count;
        w_frame_wrap = 1'b0;
        if (w_pix_en) begin
            if (r_h_count == H_LAST) begin
                w_h_next = '0;
                if (r_v_count == V_LAST) begin
                    w_v_next     = '0;
                    w_frame_wrap = 1'b1;
                end else begin
                    w_v_next = r_v_count + 1'b1;
                end
            end else begin
                w_h_next = r_h_count + 1'b1;
            end
        end else begin
            w_frame_wrap = 1'b0;
        end
    end

    // Counters and registered decode advance together on the pixel enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_count <= '0;
            r_v_count <= '0;
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_bright  <= 1'b0;
        end else if (w_pix_en) begin
            r_h_count <= w_h_next;
            r_v_count <= w_v_next;
            r_hsync   <= ~below(w_h_next, H_SYNC_X);
            r_vsync   <= ~below(w_v_next, V_SYNC_X);
            r_bright  <= in_window(w_h_next, H_START_X, H_END_X) &&
                         in_window(w_v_next, V_START_X, V_END_X);
        end
    end

    // Frame pacing: frame_start on each wrap to (0,0), move_tick every MOVE_DIV-th one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_start <= 1'b0;
            r_move_tick   <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_frame_start <= w_frame_wrap;
            r_move_tick   <= w_frame_wrap && (r_frame_cnt == FC_LAST);
            if (w_frame_wrap) begin
                if (r_frame_cnt == FC_LAST) begin
                    r_frame_cnt <= '0;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    assign pix_en      = w_pix_en;
    assign hCount      = r_h_count;
    assign vCount      = r_v_count;
    assign hSync       = r_hsync;
    assign vSync       = r_vsync;
    assign bright      = r_bright;
    assign frame_start = r_frame_start;
    assign move_tick   = r_move_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full 640x480 instance for line-level timing, plus two shrunken
// rasters (20x10 lines) for frame-level behaviour within a short run.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   k = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    logic       a_pe, a_hs, a_vs, a_br, a_fs, a_mt;
    logic [9:0] a_h, a_v;
    logic       b_pe, b_hs, b_vs, b_br, b_fs, b_mt;
    logic [9:0] b_h, b_v;
    logic       c_pe, c_hs, c_vs, c_br, c_fs, c_mt;
    logic [9:0] c_h, c_v;

    vga_timing_gen u_a (
        .clk(clk), .rst(rst), .pix_en(a_pe), .hCount(a_h), .vCount(a_v),
        .hSync(a_hs), .vSync(a_vs), .bright(a_br), .frame_start(a_fs), .move_tick(a_mt)
    );

    vga_timing_gen #(
        .CLK_DIV(4), .H_TOTAL(20), .H_SYNC(3), .H_DISP_START(5), .H_DISP_END(17),
        .V_TOTAL(10), .V_SYNC(2), .V_DISP_START(3), .V_DISP_END(8), .MOVE_DIV(2)
    ) u_b (
        .clk(clk), .rst(rst), .pix_en(b_pe), .hCount(b_h), .vCount(b_v),
        .hSync(b_hs), .vSync(b_vs), .bright(b_br), .frame_start(b_fs), .move_tick(b_mt)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_TOTAL(20), .H_SYNC(3), .H_DISP_START(5), .H_DISP_END(17),
        .V_TOTAL(10), .V_SYNC(2), .V_DISP_START(3), .V_DISP_END(8), .MOVE_DIV(1)
    ) u_c (
        .clk(clk), .rst(rst), .pix_en(c_pe), .hCount(c_h), .vCount(c_v),
        .hSync(c_hs), .vSync(c_vs), .bright(c_br), .frame_start(c_fs), .move_tick(c_mt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic check_reset(input string ph);
        chk({ph, "_a_pix_en"}, a_pe, 0);
        chk({ph, "_a_hcount"}, a_h, 0);
        chk({ph, "_a_vcount"}, a_v, 0);
        chk({ph, "_a_hsync"},  a_hs, 1);
        chk({ph, "_a_vsync"},  a_vs, 1);
        chk({ph, "_a_bright"}, a_br, 0);
        chk({ph, "_a_fstart"}, a_fs, 0);
        chk({ph, "_a_mtick"},  a_mt, 0);
        chk({ph, "_b_pix_en"}, b_pe, 0);
        chk({ph, "_b_hcount"}, b_h, 0);
        chk({ph, "_b_vcount"}, b_v, 0);
        chk({ph, "_b_hsync"},  b_hs, 1);
        chk({ph, "_b_vsync"},  b_vs, 1);
        chk({ph, "_c_pix_en"}, c_pe, 0);
        chk({ph, "_c_hcount"}, c_h, 0);
        chk({ph, "_c_fstart"}, c_fs, 0);
    endtask

    initial begin
        int hs_low, vs_low, br_cnt, overlap;
        int fs_n, mt_n, mt_alone, cfs_n, c_diff;
        int first_h, first_v, last_h, last_v;
        bit seen;

        // Reset state
        #1 rst = 1'b1;
        #2 check_reset("rst0");
        @(negedge clk);
        rst = 1'b0;
        k = 0;

        // Divider cadence and hCount stepping on the full-size raster
        for (int i = 1; i <= 40; i++) begin
            tick();
            chk("s1_pix_en", a_pe, (k % 4 == 0) ? 1 : 0);
            chk("s1_hcount", a_h, (k - 1) / 4);
            chk("s1_vcount", a_v, 0);
            chk("s1_hsync", a_hs, (k <= 4) ? 1 : 0);
            if (k <= 3) chk("s1_c_hcount", c_h, k - 1);
            if (k == 1) chk("s1_c_pix_en", c_pe, 1);
        end

        // Line wrap at (799,10) -> (0,11)
        while (k < 35200) tick();
        chk("s2_h_799", a_h, 799);
        chk("s2_v_10", a_v, 10);
        chk("s2_pix_en", a_pe, 1);
        tick();
        chk("s2_h_wrap", a_h, 0);
        chk("s2_v_11", a_v, 11);
        chk("s2_hsync_low", a_hs, 0);
        chk("s2_vsync_high", a_vs, 1);
        chk("s2_fstart", a_fs, 0);

        // One steady-state line: hSync width, no bright on a blanked line
        hs_low = 0; vs_low = 0; br_cnt = 0;
        for (int i = 0; i < 3200; i++) begin
            if (!a_hs) hs_low++;
            if (!a_vs) vs_low++;
            if (a_br) br_cnt++;
            tick();
        end
        chk("s3_hsync_clks", hs_low, 384);
        chk("s3_vsync_clks", vs_low, 0);
        chk("s3_bright_line11", br_cnt, 0);
        chk("s3_next_line_h", a_h, 0);
        chk("s3_next_line_v", a_v, 12);

        // Asynchronous reset mid-frame, between clock edges
        #3 rst = 1'b1;
        #1 check_reset("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        k = 0;

        // Frame-level behaviour on the shrunken rasters
        hs_low = 0; vs_low = 0; br_cnt = 0; overlap = 0;
        fs_n = 0; mt_n = 0; mt_alone = 0; cfs_n = 0; c_diff = 0;
        first_h = -1; first_v = -1; last_h = -1; last_v = -1; seen = 1'b0;
        for (int i = 1; i <= 3300; i++) begin
            tick();
            if (k <= 4) begin
                chk("s6_b_pix_en", b_pe, (k == 4) ? 1 : 0);
                chk("s6_b_hsync_idle", b_hs, 1);
                chk("s6_b_hcount", b_h, 0);
                chk("s6_a_pix_en", a_pe, (k == 4) ? 1 : 0);
            end
            if (k == 1) chk("s2_no_fstart_out_of_rst", b_fs, 0);
            if (k == 5) begin
                chk("s6_b_h_step", b_h, 1);
                chk("s6_b_hsync_first", b_hs, 0);
            end
            if (k == 800) begin
                chk("s2_b_h_last", b_h, 19);
                chk("s2_b_v_last", b_v, 9);
            end
            if (k == 801) begin
                chk("s2_b_h_zero", b_h, 0);
                chk("s2_b_v_zero", b_v, 0);
                chk("s2_b_fstart", b_fs, 1);
                chk("s5_b_no_tick_f1", b_mt, 0);
            end
            if (k == 802) chk("s2_b_fstart_1clk", b_fs, 0);
            if (k == 1601) begin
                chk("s5_b_fstart_f2", b_fs, 1);
                chk("s5_b_tick_f2", b_mt, 1);
            end
            if (k == 1602) chk("s5_b_tick_1clk", b_mt, 0);
            if (b_fs) fs_n++;
            if (b_mt) mt_n++;
            if (b_mt && !b_fs) mt_alone++;
            if (c_fs) cfs_n++;
            if (c_fs !== c_mt) c_diff++;
            if (k >= 801 && k <= 1600) begin
                if (!b_hs) hs_low++;
                if (!b_vs) vs_low++;
                if (b_br && (!b_hs || !b_vs)) overlap++;
                if (b_br) begin
                    br_cnt++;
                    if (!seen) begin
                        first_h = b_h;
                        first_v = b_v;
                        seen = 1'b1;
                    end
                    last_h = b_h;
                    last_v = b_v;
                end
            end
        end
        chk("s4_bright_clks", br_cnt, 240);
        chk("s4_first_h", first_h, 5);
        chk("s4_first_v", first_v, 3);
        chk("s4_last_h", last_h, 16);
        chk("s4_last_v", last_v, 7);
        chk("s4_bright_in_sync", overlap, 0);
        chk("s3_b_hsync_clks", hs_low, 120);
        chk("s3_b_vsync_clks", vs_low, 160);
        chk("s5_b_fstart_count", fs_n, 4);
        chk("s5_b_tick_count", mt_n, 2);
        chk("s5_b_tick_alone", mt_alone, 0);
        chk("s5_c_fstart_count", cfs_n, 16);
        chk("s5_c_tick_eq_fstart", c_diff, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
